// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Byte-offset bits [1:0] are never part of the tag.
  function automatic int tag_w(input int num_lines, input int line_words);
    return 30 - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache in one bundle.
//
// Memory handshake: mem_req/mem_addr are registered by the cache and held stable
// until the rising edge on which mem_ack=1; that edge transfers mem_rdata. An ack in
// the same cycle the request first appears is legal. mem_ack is ignored when
// mem_req=0.
interface icache_if;
  logic [31:0] pc_addr;
  logic        flush;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  pc_addr, flush, mem_ack, mem_rdata,
    output inst_out, inst_valid, stall, mem_req, mem_addr
  );

  modport master (
    output pc_addr, flush, mem_ack, mem_rdata,
    input  inst_out, inst_valid, stall, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_data_ram.sv
// Line data storage: one synchronous write port, one asynchronous read port.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clock,
  input  logic                          we,
  input  logic [idx_w(NUM_LINES)-1:0]   w_idx,
  input  logic [off_w(LINE_WORDS)-1:0]  w_off,
  input  logic [31:0]                   w_data,
  input  logic [idx_w(NUM_LINES)-1:0]   r_idx,
  input  logic [off_w(LINE_WORDS)-1:0]  r_off,
  output logic [31:0]                   r_data
);

  logic [31:0] mem [NUM_LINES*LINE_WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[{w_idx, w_off}] <= w_data;
  end

  assign r_data = mem[{r_idx, r_off}];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: zero-latency hits in IDLE, sequential
// word-by-word line refill on a miss.
module icache
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic     clock,
  input  logic     reset_n,
  icache_if.slave  bus,
  output state_t   dbg_state
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(NUM_LINES, LINE_WORDS);

  state_t             state, state_next;
  logic [OFF_W-1:0]   pc_off, cnt;
  logic [IDX_W-1:0]   pc_idx, fill_idx;
  logic [TAG_W-1:0]   pc_tag, fill_tag;
  logic [TAG_W-1:0]   tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic               poison, req_q;
  logic [31:0]        addr_q, rd_data;
  logic               hit, start, ram_we, last_ack;
  logic               unused_pc_bits;

  assign pc_off = bus.pc_addr[2 +: OFF_W];
  assign pc_idx = bus.pc_addr[2 + OFF_W +: IDX_W];
  assign pc_tag = bus.pc_addr[31 -: TAG_W];
  assign unused_pc_bits = ^bus.pc_addr[1:0];

  assign hit      = (state == IDLE) && valid[pc_idx] && (tags[pc_idx] == pc_tag);
  // A flush on the miss edge wins; the still-missing PC restarts the refill a cycle later.
  assign start    = (state == IDLE) && !hit && !bus.flush;
  assign ram_we   = (state == REFILL) && bus.mem_ack;
  assign last_ack = ram_we && (cnt == {OFF_W{1'b1}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = REFILL;
      REFILL:  if (last_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      poison   <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= 32'h0;
      fill_idx <= '0;
      fill_tag <= '0;
    end else begin
      if (start) begin
        fill_idx <= pc_idx;
        fill_tag <= pc_tag;
        cnt      <= '0;
        poison   <= 1'b0;
        req_q    <= 1'b1;
        addr_q   <= {bus.pc_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
      end else if (ram_we) begin
        cnt    <= cnt + OFF_W'(1);
        addr_q <= addr_q + 32'd4;
        if (last_ack) req_q <= 1'b0;
      end
      if (bus.flush && state == REFILL) poison <= 1'b1;
    end
  end

  // A flush on the final-ack edge also keeps the new line invalid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                valid <= '0;
    else if (bus.flush)                          valid <= '0;
    else if (last_ack && !poison)                valid[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (last_ack) tags[fill_idx] <= fill_tag;
  end

  icache_data_ram #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_data_ram (
    .clock  (clock),
    .we     (ram_we),
    .w_idx  (fill_idx),
    .w_off  (cnt),
    .w_data (bus.mem_rdata),
    .r_idx  (pc_idx),
    .r_off  (pc_off),
    .r_data (rd_data)
  );

  assign bus.inst_valid = hit;
  assign bus.stall      = !hit;
  assign bus.inst_out   = hit ? rd_data : NOP;
  assign bus.mem_req    = req_q;
  assign bus.mem_addr   = addr_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: hit table plus hand-written miss, wait-state, flush
// and reset sequences against a memory whose word at address a is C0DE_0000|a[15:0].
module tb_icache;
  import icache_pkg::*;

  logic   clock;
  logic   reset_n;
  state_t dbg_state;
  int     checks;
  int     errors;

  icache_if ifc ();

  icache #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign ifc.mem_rdata = mem_word(ifc.mem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] inst;
  } hit_vec_t;

  hit_vec_t vecs [7];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Checks the request stream of a full refill with ack tied high, starting
  // in the cycle right after the miss, and the hit in the cycle after it.
  task automatic run_fill(input string name, input logic [31:0] base);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_bit({name, "_req"}, ifc.mem_req, 1'b1);
      check({name, "_addr"}, ifc.mem_addr, base + 32'(4 * (c - 1)));
      check_bit({name, "_busy_valid"}, ifc.inst_valid, 1'b0);
    end
    tick();
    check_bit({name, "_hit_valid"}, ifc.inst_valid, 1'b1);
    check({name, "_hit_inst"}, ifc.inst_out, mem_word(ifc.pc_addr));
    check_bit({name, "_hit_req"}, ifc.mem_req, 1'b0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset_n     = 1'b0;
    ifc.pc_addr = 32'h0;
    ifc.flush   = 1'b0;
    ifc.mem_ack = 1'b0;

    vecs[0] = '{32'h0000_0000, 1'b1, 32'hC0DE_0000};
    vecs[1] = '{32'h0000_0004, 1'b1, 32'hC0DE_0004};
    vecs[2] = '{32'h0000_0008, 1'b1, 32'hC0DE_0008};
    vecs[3] = '{32'h0000_000C, 1'b1, 32'hC0DE_000C};
    vecs[4] = '{32'h0000_000E, 1'b1, 32'hC0DE_000C};
    vecs[5] = '{32'h0000_0010, 1'b0, NOP};
    vecs[6] = '{32'h0000_0100, 1'b0, NOP};

    // Reset state.
    repeat (3) tick();
    check_bit("rst_valid", ifc.inst_valid, 1'b0);
    check_bit("rst_stall", ifc.stall, 1'b1);
    check("rst_inst", ifc.inst_out, NOP);
    check_bit("rst_req", ifc.mem_req, 1'b0);
    check("rst_addr", ifc.mem_addr, 32'h0);
    check_bit("rst_state", dbg_state, IDLE);

    // Cold miss at 0x0, ack tied high.
    reset_n     = 1'b1;
    ifc.mem_ack = 1'b1;
    #1;
    check_bit("cold_c0_valid", ifc.inst_valid, 1'b0);
    check_bit("cold_c0_req", ifc.mem_req, 1'b0);
    run_fill("cold", 32'h0);
    check_bit("cold_stall", ifc.stall, 1'b0);

    // Hit table: combinational, no clock edge between vectors.
    for (int i = 0; i < 7; i++) begin
      ifc.pc_addr = vecs[i].pc;
      #1;
      check_bit($sformatf("tbl%0d_valid", i), ifc.inst_valid, vecs[i].valid);
      check($sformatf("tbl%0d_inst", i), ifc.inst_out, vecs[i].inst);
      check_bit($sformatf("tbl%0d_stall", i), ifc.stall, !vecs[i].valid);
      check_bit($sformatf("tbl%0d_req", i), ifc.mem_req, 1'b0);
    end
    ifc.pc_addr = 32'h0;
    tick();

    // Conflict on index 0, then the original line misses again.
    ifc.pc_addr = 32'h0000_0100;
    #1;
    check_bit("conf_c0_valid", ifc.inst_valid, 1'b0);
    run_fill("conf100", 32'h0000_0100);
    ifc.pc_addr = 32'h0;
    #1;
    check_bit("conf_back_miss", ifc.inst_valid, 1'b0);
    run_fill("conf000", 32'h0);

    // Wait states: ack every 4th request cycle, PC moves mid-refill.
    ifc.mem_ack = 1'b0;
    ifc.pc_addr = 32'h0000_0040;
    tick();
    for (int k = 0; k < 16; k++) begin
      ifc.mem_ack = ((k % 4) == 3);
      if (k == 5) ifc.pc_addr = 32'h0000_0200;
      #1;
      check_bit($sformatf("ws%0d_req", k), ifc.mem_req, 1'b1);
      check($sformatf("ws%0d_addr", k), ifc.mem_addr, 32'h40 + 32'(4 * (k / 4)));
      tick();
    end
    ifc.mem_ack = 1'b0;
    ifc.pc_addr = 32'h0000_0044;
    #1;
    check_bit("ws_done_req", ifc.mem_req, 1'b0);
    check_bit("ws_hit_valid", ifc.inst_valid, 1'b1);
    check("ws_hit_inst", ifc.inst_out, 32'hC0DE_0044);

    // Flush during refill of 0x80 after word 1.
    ifc.mem_ack = 1'b1;
    ifc.pc_addr = 32'h0000_0080;
    tick();
    check("fl_w0_addr", ifc.mem_addr, 32'h80);
    tick();
    check("fl_w1_addr", ifc.mem_addr, 32'h84);
    tick();
    check("fl_w2_addr", ifc.mem_addr, 32'h88);
    ifc.flush = 1'b1;
    tick();
    ifc.flush = 1'b0;
    check_bit("fl_w3_req", ifc.mem_req, 1'b1);
    check("fl_w3_addr", ifc.mem_addr, 32'h8C);
    tick();
    check_bit("fl_poison_valid", ifc.inst_valid, 1'b0);
    check_bit("fl_poison_req", ifc.mem_req, 1'b0);
    run_fill("fl_refill", 32'h80);

    // Flush coincident with a miss in IDLE: refill starts one cycle late.
    ifc.pc_addr = 32'h0;
    ifc.flush   = 1'b1;
    #1;
    check_bit("flmiss_valid", ifc.inst_valid, 1'b0);
    tick();
    ifc.flush = 1'b0;
    check_bit("flmiss_req_late", ifc.mem_req, 1'b0);
    tick();
    check_bit("flmiss_req", ifc.mem_req, 1'b1);
    check("flmiss_w0_addr", ifc.mem_addr, 32'h0);
    tick();
    check("flmiss_w1_addr", ifc.mem_addr, 32'h4);
    tick();
    check("flmiss_w2_addr", ifc.mem_addr, 32'h8);

    // Reset at word 2 of the refill.
    reset_n = 1'b0;
    #1;
    check_bit("rstr_req", ifc.mem_req, 1'b0);
    check_bit("rstr_valid", ifc.inst_valid, 1'b0);
    check("rstr_addr", ifc.mem_addr, 32'h0);
    tick();
    reset_n     = 1'b1;
    ifc.pc_addr = 32'h80;
    #1;
    check_bit("rstr_80_invalid", ifc.inst_valid, 1'b0);
    ifc.pc_addr = 32'h0;
    #1;
    check_bit("rstr_0_miss", ifc.inst_valid, 1'b0);
    run_fill("rstr_refill", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
